// File: rtl/dp_pkg.sv
// dp_pkg: opcode encodings, FSM state codes and the signed-overflow helper
// shared by datapath_mc and its register file.
package dp_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_ADDI  = 3'b100;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_READ = 3'd1;
    localparam state_t ST_EXEC = 3'd2;
    localparam state_t ST_MEM  = 3'd3;
    localparam state_t ST_WB   = 3'd4;

    // Two's-complement add overflows when both operands share a sign the sum lacks.
    function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_s);
        return (sign_a == sign_b) && (sign_s != sign_a);
    endfunction

    function automatic logic is_mem_op(input logic [2:0] op_code);
        return (op_code == OP_LOAD) || (op_code == OP_STORE);
    endfunction

endpackage

// File: rtl/dp_regfile.sv
// dp_regfile: NREG x WIDTH register file, two combinational read ports and one
// write port. Register 0 always reads zero and ignores writes.
module dp_regfile
    import dp_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NREG  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NREG)-1:0]  rd_addr_a,
    input  logic [$clog2(NREG)-1:0]  rd_addr_b,
    output logic [WIDTH-1:0]         rd_data_a,
    output logic [WIDTH-1:0]         rd_data_b,
    input  logic                     wr_en,
    input  logic [$clog2(NREG)-1:0]  wr_addr,
    input  logic [WIDTH-1:0]         wr_data
);

    logic [WIDTH-1:0] regs [NREG];

    // Register storage: cleared on reset, writes to entry 0 dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // No write-to-read bypass: a same-cycle read returns the old value.
    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/datapath_mc.sv
// datapath_mc: multi-cycle load/store/ALU datapath with register file and
// synchronous data RAM. Build option DATAPATH_MC_OVF_TRAP_EN makes signed
// overflow on ADD/SUB/ADDI raise err and drop the register write.
//
// state | meaning
// IDLE  | waiting for start, captures instruction fields
// READ  | register file read into dataOutA/dataOutB
// EXEC  | sum/difference/address computed into result
// MEM   | LOAD/STORE only: RAM read or write at result
// WB    | done pulse, register write-back unless suppressed
module datapath_mc
    import dp_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NREG  = 32,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [2:0]               op,
    input  logic [$clog2(NREG)-1:0]  ra,
    input  logic [$clog2(NREG)-1:0]  rb,
    input  logic [$clog2(NREG)-1:0]  rw,
    input  logic [WIDTH-1:0]         imm,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [WIDTH-1:0]         dataOutA,
    output logic [WIDTH-1:0]         dataOutB,
    output logic [WIDTH-1:0]         result
);

    localparam int RW = $clog2(NREG);
    localparam int AW = $clog2(DEPTH);

`ifdef DATAPATH_MC_OVF_TRAP_EN
    localparam logic OVF_TRAP = 1'b1;
`else
    localparam logic OVF_TRAP = 1'b0;
`endif

    state_t           state;
    logic [2:0]       op_q;
    logic [RW-1:0]    ra_q;
    logic [RW-1:0]    rb_q;
    logic [RW-1:0]    rw_q;
    logic [WIDTH-1:0] imm_q;
    logic             err_q;

    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;
    logic [WIDTH-1:0] exec_val;
    logic             exec_ovf;
    logic             exec_ill;

    logic [WIDTH-1:0] ram [DEPTH];
    logic [WIDTH-1:0] ram_q;
    logic [AW-1:0]    ram_addr;

    logic             wb_en;
    logic [WIDTH-1:0] wb_data;

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_WB);
    assign err      = (state == ST_WB) && err_q;
    assign ram_addr = result[AW-1:0];

    // Errored ops (illegal or trapped overflow) and STORE leave the register file alone.
    assign wb_en   = (state == ST_WB) && (op_q != OP_STORE) && !err_q;
    assign wb_data = (op_q == OP_LOAD) ? ram_q : result;

    dp_regfile #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (ra_q),
        .rd_addr_b (rb_q),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_en     (wb_en),
        .wr_addr   (rw_q),
        .wr_data   (wb_data)
    );

    // EXEC arithmetic: address, sum or difference, plus overflow and illegal-op flags.
    always_comb begin
        exec_val = '0;
        exec_ovf = 1'b0;
        exec_ill = 1'b0;
        case (op_q)
            OP_LOAD, OP_STORE: begin
                exec_val = dataOutB + imm_q;
            end
            OP_ADD: begin
                exec_val = dataOutA + dataOutB;
                exec_ovf = add_ovf(dataOutA[WIDTH-1], dataOutB[WIDTH-1], exec_val[WIDTH-1]);
            end
            OP_SUB: begin
                exec_val = dataOutA - dataOutB;
                exec_ovf = add_ovf(dataOutA[WIDTH-1], ~dataOutB[WIDTH-1], exec_val[WIDTH-1]);
            end
            OP_ADDI: begin
                exec_val = dataOutA + imm_q;
                exec_ovf = add_ovf(dataOutA[WIDTH-1], imm_q[WIDTH-1], exec_val[WIDTH-1]);
            end
            default: begin
                exec_ill = 1'b1;
            end
        endcase
    end

    // Control FSM and the registered operand/result pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rw_q     <= '0;
            imm_q    <= '0;
            err_q    <= 1'b0;
            dataOutA <= '0;
            dataOutB <= '0;
            result   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        ra_q  <= ra;
                        rb_q  <= rb;
                        rw_q  <= rw;
                        imm_q <= imm;
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    dataOutA <= rd_data_a;
                    dataOutB <= rd_data_b;
                    state    <= ST_EXEC;
                end
                ST_EXEC: begin
                    result <= exec_val;
                    err_q  <= exec_ill || (OVF_TRAP && exec_ovf);
                    state  <= is_mem_op(op_q) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    state <= ST_WB;
                end
                ST_WB: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Data RAM: no reset, accessed only in MEM; read data lands for WB.
    always_ff @(posedge clk) begin
        if (state == ST_MEM) begin
            if (op_q == OP_STORE) begin
                ram[ram_addr] <= dataOutA;
            end
            ram_q <= ram[ram_addr];
        end
    end

endmodule

// File: doc/datapath_mc.md
DATAPATH_MC -- requirements
Module: datapath_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data/register width in bits.
REQ-002 SHALL have parameter NREG, default 32, register-file entries (power of 2, >=2).
REQ-003 SHALL have parameter DEPTH, default 256, data-RAM words (power of 2).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-007 SHALL have port op  input  3  000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 ADDI; 101-111 illegal.
REQ-008 SHALL have ports ra, rb, rw  input  $clog2(NREG) each  source A, source B, destination.
REQ-009 SHALL have port imm  input  WIDTH  offset (LOAD/STORE) or immediate (ADDI).
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse on completion.
REQ-012 SHALL have port err  output  1  valid with done; illegal op or trapped overflow.
REQ-013 SHALL have ports dataOutA, dataOutB  output  WIDTH  registered operands read in READ.
REQ-014 SHALL have port result  output  WIDTH  registered EXEC result (sum/difference or address).

Function
REQ-015 SHALL implement FSM IDLE, READ, EXEC, MEM, WB; start&&IDLE captures op, ra, rb, rw, imm and moves to READ.
REQ-016 SHALL sequence LOAD/STORE READ->EXEC->MEM->WB->IDLE and ADD/SUB/ADDI/illegal READ->EXEC->WB->IDLE.
REQ-017 SHALL assert done and err only in WB; done occurs 4 cycles after accept for LOAD/STORE, 3 for others.
REQ-018 SHALL ignore start while busy; no queuing.
REQ-019 SHALL compute in EXEC: LOAD/STORE addr = rb + imm; ADD ra+rb; SUB ra-rb; ADDI ra+imm; all modulo 2^WIDTH.
REQ-020 SHALL use the low $clog2(DEPTH) bits of the address; higher bits are ignored (wrap).
REQ-021 SHALL for STORE write dataOutA to RAM in MEM; for LOAD perform a synchronous RAM read in MEM and write it to rw in WB.
REQ-022 SHALL write result to rw in WB for ADD/SUB/ADDI; STORE and illegal ops perform no register write.
REQ-023 SHALL hard-wire register 0 to zero; writes to it are discarded.
REQ-024 SHALL, for a WB write and a READ of the same register in the same cycle, return the old value (no bypass; impossible in single-issue).
REQ-025 SHALL set err=1 with done for illegal ops; result holds 0.

Reset
REQ-026 SHALL, on rst_n low (including mid-operation), force IDLE and clear busy, done, err, dataOutA, dataOutB, result and all registers to 0, abandoning any in-flight write.
REQ-027 SHALL NOT reset RAM contents.

Configuration
REQ-028 SHALL recognise macro DATAPATH_MC_OVF_TRAP_EN.
REQ-029 SHALL with the macro: detect signed overflow on ADD/SUB/ADDI, suppress the WB write, and set err=1 with done.
REQ-030 SHALL without the macro: wrap silently and keep err=0 for arithmetic ops.

Structure
REQ-031 SHALL place op encodings and the FSM state enum in shared package dp_pkg.
REQ-032 SHALL implement the register file as sub-module dp_regfile (2 read, 1 write, async reset, reg 0 zero).

Verification
REQ-033 SHALL test reset: rst_n=0 mid-LOAD -> IDLE next edge, busy=0, done never pulses, target register stays 0.
REQ-034 SHALL test ADDI r1=0+5, ADDI r2=0+7, ADD r3=r1+r2 -> result=12, done 3 cycles after each accept, dataOutA=5, dataOutB=7.
REQ-035 SHALL test ADDI r1=0x2A, STORE r1 at rb=r0, imm=DEPTH+3, then LOAD r4 from imm=3 -> r4=0x2A, done 4 cycles after accept.
REQ-036 SHALL test SUB r0=r1-r2 with r1=1, r2=3 -> result=0xFFFF_FFFF_FFFF_FFFE, r0 reads 0 afterwards.
REQ-037 SHALL test overflow r1=0x7FFF_FFFF_FFFF_FFFF plus ADDI 1 -> with macro err=1, r1 unchanged; without, r1=0x8000_0000_0000_0000, err=0.
REQ-038 SHALL test op=110 plus start held high while busy -> one done with err=1, no extra transaction accepted.
